// File: rtl/avg_thresh_mon.sv
// Mean threshold monitor: divide-by-4 mean, hysteresis set/clear with debounce, saturating alarm-entry count.
// Define AVG_THRESH_PEAK_EN to add the peak-mean-during-alarm output.
module avg_thresh_mon #(
   parameter int unsigned WARMUP   = 6,
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      sum_in,
   input  logic [63:0]      high_th,
   input  logic [63:0]      low_th,
   input  logic             clr_cnt,
   output logic [63:0]      mean,
   output logic             ready,
   output logic             alarm,
   output logic [CNT_W-1:0] event_cnt
`ifdef AVG_THRESH_PEAK_EN
   ,
   output logic [63:0]      peak
`endif
);

   typedef enum logic [2:0] {WARM, IDLE, ARM, ALARM, CLR} state_t;

   localparam logic [7:0] LP_WARM_LAST = 8'(WARMUP - 1);
   localparam logic [7:0] LP_DEB_LAST  = 8'(DEBOUNCE - 1);

   state_t           r_state;
   logic [7:0]       r_warm;
   logic [7:0]       r_run;
   logic [63:0]      r_mean;
   logic             r_ready;
   logic             r_alarm;
   logic [CNT_W-1:0] r_event;

   logic w_above;
   logic w_below;
   logic w_entry;
   logic w_unused;

   assign w_above  = r_mean > high_th;
   assign w_below  = r_mean < low_th;
   assign w_unused = ^sum_in[1:0];

   // Entry into ALARM from the set side only; CLR->ALARM is a bounce, not a new event
   always_comb begin
      w_entry = 1'b0;
      if (r_state == IDLE && w_above && DEBOUNCE == 1)
         w_entry = 1'b1;
      else if (r_state == ARM && w_above && r_run == LP_DEB_LAST)
         w_entry = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= WARM;
         r_warm  <= '0;
         r_run   <= '0;
         r_mean  <= '0;
         r_ready <= 1'b0;
         r_alarm <= 1'b0;
         r_event <= '0;
      end else begin
         r_mean <= {2'b00, sum_in[63:2]};
         case (r_state)
            WARM: begin
               r_warm <= r_warm + 8'd1;
               if (r_warm == LP_WARM_LAST) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            IDLE: begin
               if (w_above) begin
                  if (DEBOUNCE == 1) begin
                     r_state <= ALARM;
                     r_alarm <= 1'b1;
                  end else begin
                     r_state <= ARM;
                     r_run   <= 8'd1;
                  end
               end
            end
            ARM: begin
               if (w_above) begin
                  if (r_run == LP_DEB_LAST) begin
                     r_state <= ALARM;
                     r_alarm <= 1'b1;
                     r_run   <= '0;
                  end else begin
                     r_run <= r_run + 8'd1;
                  end
               end else begin
                  r_state <= IDLE;
                  r_run   <= '0;
               end
            end
            ALARM: begin
               if (w_below) begin
                  if (DEBOUNCE == 1) begin
                     r_state <= IDLE;
                     r_alarm <= 1'b0;
                  end else begin
                     r_state <= CLR;
                     r_run   <= 8'd1;
                  end
               end
            end
            CLR: begin
               if (w_below) begin
                  if (r_run == LP_DEB_LAST) begin
                     r_state <= IDLE;
                     r_alarm <= 1'b0;
                     r_run   <= '0;
                  end else begin
                     r_run <= r_run + 8'd1;
                  end
               end else begin
                  r_state <= ALARM;
                  r_run   <= '0;
               end
            end
            default: r_state <= WARM;
         endcase

         if (clr_cnt)
            r_event <= '0;
         else if (w_entry && r_event != '1)
            r_event <= r_event + 1'b1;
      end
   end

   assign mean      = r_mean;
   assign ready     = r_ready;
   assign alarm     = r_alarm;
   assign event_cnt = r_event;

`ifdef AVG_THRESH_PEAK_EN
   logic [63:0] r_peak;

   always_ff @(posedge clk) begin
      if (reset || clr_cnt)
         r_peak <= '0;
      else if (w_entry)
         r_peak <= r_mean;
      else if ((r_state == ALARM || r_state == CLR) && r_mean > r_peak)
         r_peak <= r_mean;
   end

   assign peak = r_peak;
`endif

endmodule

// File: tb/tb_avg_thresh_mon.sv
// Directed bench for avg_thresh_mon: default instance plus a CNT_W=4, DEBOUNCE=1, WARMUP=1 instance.
module tb_avg_thresh_mon;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clr_cnt;
   logic [63:0] sum_in, high_th, low_th;
   logic [63:0] mean;
   logic        ready, alarm;
   logic [15:0] event_cnt;
`ifdef AVG_THRESH_PEAK_EN
   logic [63:0] peak;
`endif

   logic        reset2, clr2;
   logic [63:0] sum2, high2, low2;
   logic [63:0] mean2;
   logic        ready2, alarm2;
   logic [3:0]  event2;
`ifdef AVG_THRESH_PEAK_EN
   logic [63:0] peak2;
`endif

   int total = 0;
   int bad   = 0;

   logic [63:0] bseq [7] = '{64'd160, 64'd160, 64'd240, 64'd160, 64'd160, 64'd160, 64'd160};

   avg_thresh_mon #(.WARMUP(6), .DEBOUNCE(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .sum_in(sum_in), .high_th(high_th), .low_th(low_th),
      .clr_cnt(clr_cnt), .mean(mean), .ready(ready), .alarm(alarm), .event_cnt(event_cnt)
`ifdef AVG_THRESH_PEAK_EN
      , .peak(peak)
`endif
   );

   avg_thresh_mon #(.WARMUP(1), .DEBOUNCE(1), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset2), .sum_in(sum2), .high_th(high2), .low_th(low2),
      .clr_cnt(clr2), .mean(mean2), .ready(ready2), .alarm(alarm2), .event_cnt(event2)
`ifdef AVG_THRESH_PEAK_EN
      , .peak(peak2)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic enter_alarm(input string tag);
      sum_in = 64'd404;
      repeat (5) tick();
      chk(tag, 64'(alarm), 64'd1);
   endtask

   initial begin
      reset = 1'b1; clr_cnt = 1'b0; sum_in = 64'h100; high_th = 64'h10; low_th = 64'h8;
      reset2 = 1'b1; clr2 = 1'b0; sum2 = '0; high2 = 64'd10; low2 = 64'd5;
      tick();
      tick();
      chk("rst_mean", mean, 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_alarm", 64'(alarm), 64'd0);
      chk("rst_event", 64'(event_cnt), 64'd0);
      reset = 1'b0; reset2 = 1'b0;

      // warm-up: cycles 0..5 not ready, cycle 6 ready
      for (int c = 0; c < 6; c++) begin
         chk("warm_ready", 64'(ready), 64'd0);
         chk("warm_alarm", 64'(alarm), 64'd0);
         if (c == 0) chk("warm2_ready0", 64'(ready2), 64'd0);
         if (c == 1) chk("warm2_ready1", 64'(ready2), 64'd1);
         if (c == 1) chk("mean_0x40", mean, 64'h40);
         tick();
      end
      chk("ready6", 64'(ready), 64'd1);
      chk("alarm6", 64'(alarm), 64'd0);
      for (int k = 7; k <= 9; k++) begin
         tick();
         chk("warm_arm_alarm", 64'(alarm), 64'd0);
      end
      tick();
      chk("warm_alarm10", 64'(alarm), 64'd1);
      chk("warm_event10", 64'(event_cnt), 64'd1);

      high_th = 64'd100; low_th = 64'd50; sum_in = '0;
      repeat (6) tick();
      chk("first_clear", 64'(alarm), 64'd0);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("clr_event", 64'(event_cnt), 64'd0);

      // 4 qualifying sums: alarm at t+5
      sum_in = 64'd404;
      repeat (4) tick();
      sum_in = '0;
      chk("deb_t4", 64'(alarm), 64'd0);
      tick();
      chk("deb_t5", 64'(alarm), 64'd1);
      chk("deb_event", 64'(event_cnt), 64'd1);
      repeat (6) tick();
      chk("deb_cleared", 64'(alarm), 64'd0);
      chk("deb_event_hold", 64'(event_cnt), 64'd1);

      // 3 qualifying sums only
      sum_in = 64'd404;
      repeat (3) tick();
      sum_in = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("short_run", 64'(alarm), 64'd0);
      end

      // mean exactly 100 never sets
      for (int i = 0; i < 8; i++) begin
         sum_in = 64'd400 + 64'(i % 4);
         tick();
         chk("eq_high", 64'(alarm), 64'd0);
      end

      enter_alarm("eq_enter");
      for (int i = 0; i < 6; i++) begin
         sum_in = 64'd200 + 64'(i % 4);
         tick();
         chk("eq_low_hold", 64'(alarm), 64'd1);
      end
      sum_in = 64'd196;
      repeat (4) tick();
      chk("low_u4", 64'(alarm), 64'd1);
      sum_in = 64'd200;
      tick();
      chk("low_u5", 64'(alarm), 64'd0);
      repeat (3) tick();

      // bounce: 40,40,60,40,40,40,40
      enter_alarm("bounce_enter");
      for (int i = 0; i < 7; i++) begin
         sum_in = bseq[i];
         chk("bounce_hold", 64'(alarm), 64'd1);
         tick();
      end
      chk("bounce_v7", 64'(alarm), 64'd1);
      tick();
      chk("bounce_v8", 64'(alarm), 64'd0);
      chk("bounce_event", 64'(event_cnt), 64'd3);

      // small-counter instance: one entry per two cycles
      for (int k = 1; k <= 20; k++) begin
         sum2 = 64'd100;
         tick();
         sum2 = '0;
         tick();
         chk("sat_event", 64'(event2), 64'((k < 15) ? k : 15));
         chk("sat_alarm", 64'(alarm2), 64'd1);
      end
      sum2 = 64'd100;
      tick();
      clr2 = 1'b1;
      sum2 = '0;
      tick();
      clr2 = 1'b0;
      chk("clr_vs_entry_event", 64'(event2), 64'd0);
      chk("clr_vs_entry_alarm", 64'(alarm2), 64'd1);
      sum2 = 64'd100;
      tick();
      sum2 = '0;
      tick();
      chk("after_clr_event", 64'(event2), 64'd1);

      // peak tracking and reset while in CLR
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("pk_clr_event", 64'(event_cnt), 64'd0);
`ifdef AVG_THRESH_PEAK_EN
      chk("pk_clr_peak", peak, 64'd0);
`endif
      enter_alarm("pk_enter");
`ifdef AVG_THRESH_PEAK_EN
      chk("pk_load", peak, 64'd101);
`endif
      sum_in = 64'd480;
      tick();
      sum_in = 64'd600;
      tick();
      sum_in = 64'd520;
      tick();
      sum_in = '0;
      tick();
      chk("pk_alarm_w9", 64'(alarm), 64'd1);
`ifdef AVG_THRESH_PEAK_EN
      chk("pk_max_w9", peak, 64'd150);
`endif
      tick();
      chk("pk_alarm_clr", 64'(alarm), 64'd1);
      chk("pk_event", 64'(event_cnt), 64'd1);
`ifdef AVG_THRESH_PEAK_EN
      chk("pk_max_clr", peak, 64'd150);
`endif
      reset = 1'b1;
      tick();
      chk("mid_rst_alarm", 64'(alarm), 64'd0);
      chk("mid_rst_ready", 64'(ready), 64'd0);
      chk("mid_rst_event", 64'(event_cnt), 64'd0);
      chk("mid_rst_mean", mean, 64'd0);
`ifdef AVG_THRESH_PEAK_EN
      chk("mid_rst_peak", peak, 64'd0);
`endif
      reset = 1'b0;
      tick();
      chk("rewarm_ready", 64'(ready), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
